// File: rtl/avalon_sample_slave.sv
// Avalon-MM sample buffer slave: zero-wait writes into a DEPTH-word buffer,
// reads served after READ_WAIT waitrequest cycles, frame_done after the last word.
module avalon_sample_slave #(
   parameter int DEPTH     = 512,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 16,
   parameter int READ_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] slave_address,
   input  logic              slave_read,
   input  logic              slave_write,
   input  logic [DATA_W-1:0] slave_write_data,
   input  logic              hold,
   output logic [DATA_W-1:0] slave_read_data,
   output logic              slave_waitrequest,
   output logic [1:0]        slave_response,
   output logic              frame_done,
   output logic [ADDR_W:0]   write_count,
   output logic [1:0]        fsm_state
);

   // Handshake: an access completes on a rising edge where the request is
   // high and slave_waitrequest is low; response is valid in that cycle only.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RWAIT = 2'd1,
      RDONE = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
   localparam logic [1:0]        RESP_OKAY = 2'b00;
   localparam logic [1:0]        RESP_ERR  = 2'b10;

   state_t              state;
   logic [3:0]          wait_cnt;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_oor;
   logic                rd_err;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                addr_ok;
   logic                wr_commit;
   logic                wr_ok;

   assign addr_ok   = {1'b0, slave_address} < DEPTH_W;
   // A write only commits alone in IDLE; a concurrent read always wins.
   assign wr_commit = (state == IDLE) && !rst && slave_write && !slave_read && !hold;
   assign wr_ok     = wr_commit && addr_ok;
   assign fsm_state = state;

   always_comb begin
      slave_waitrequest = 1'b0;
      slave_response    = RESP_OKAY;
      if (rst) begin
         slave_waitrequest = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (slave_read) begin
                  slave_waitrequest = 1'b1;
               end else if (slave_write) begin
                  slave_waitrequest = hold;
                  if (!hold && !addr_ok) slave_response = RESP_ERR;
               end
            end
            RWAIT:   slave_waitrequest = 1'b1;
            RDONE:   slave_response = rd_err ? RESP_ERR : RESP_OKAY;
            default: slave_waitrequest = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[slave_address] <= slave_write_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         wait_cnt        <= 4'd0;
         rd_addr         <= '0;
         rd_oor          <= 1'b0;
         rd_err          <= 1'b0;
         slave_read_data <= '0;
         frame_done      <= 1'b0;
         write_count     <= '0;
      end else begin
         frame_done <= 1'b0;
         if (wr_ok) begin
            if (slave_address == LAST_ADDR) begin
               write_count <= '0;
               frame_done  <= 1'b1;
            end else if (write_count != DEPTH_W) begin
               write_count <= write_count + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (slave_read) begin
                  rd_addr <= slave_address;
                  rd_oor  <= !addr_ok;
                  rd_err  <= !addr_ok || slave_write;
                  if (READ_WAIT > 1) begin
                     state    <= RWAIT;
                     wait_cnt <= 4'(READ_WAIT-1);
                  end else begin
                     state           <= RDONE;
                     slave_read_data <= addr_ok ? mem[slave_address] : '0;
                  end
               end
            end
            RWAIT: begin
               if (wait_cnt <= 4'd1) begin
                  state           <= RDONE;
                  wait_cnt        <= 4'd0;
                  slave_read_data <= rd_oor ? '0 : mem[rd_addr];
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RDONE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_sample_slave.sv
// Bench for avalon_sample_slave: unit 0 (DEPTH 512, READ_WAIT 1) and
// unit 1 (DEPTH 300, READ_WAIT 3) driven independently, sharing clk/rst.
module tb_avalon_sample_slave;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0][8:0]  addr;
   logic [1:0]       rd;
   logic [1:0]       wr;
   logic [1:0][15:0] wdata;
   logic [1:0]       hold;
   logic [1:0][15:0] rdata;
   logic [1:0]       wreq;
   logic [1:0][1:0]  resp;
   logic [1:0]       fd;
   logic [1:0][9:0]  wcnt;
   logic [1:0][1:0]  st;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   int depth_of [2] = '{512, 300};
   int rw_of [2]    = '{1, 3};
   int exp_cnt [2]  = '{0, 0};
   logic [15:0] model [2][512];
   logic [15:0] exp_q[$];
   logic [1:0]  exp_resp_q[$];

   always #5 clk = ~clk;

   avalon_sample_slave #(.DEPTH(512), .ADDR_W(9), .DATA_W(16), .READ_WAIT(1)) u0 (
      .clk(clk), .rst(rst), .slave_address(addr[0]), .slave_read(rd[0]),
      .slave_write(wr[0]), .slave_write_data(wdata[0]), .hold(hold[0]),
      .slave_read_data(rdata[0]), .slave_waitrequest(wreq[0]),
      .slave_response(resp[0]), .frame_done(fd[0]), .write_count(wcnt[0]),
      .fsm_state(st[0]));

   avalon_sample_slave #(.DEPTH(300), .ADDR_W(9), .DATA_W(16), .READ_WAIT(3)) u1 (
      .clk(clk), .rst(rst), .slave_address(addr[1]), .slave_read(rd[1]),
      .slave_write(wr[1]), .slave_write_data(wdata[1]), .hold(hold[1]),
      .slave_read_data(rdata[1]), .slave_waitrequest(wreq[1]),
      .slave_response(resp[1]), .frame_done(fd[1]), .write_count(wcnt[1]),
      .fsm_state(st[1]));

   always @(negedge clk) if (fd[0] === 1'b1) fd_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input int u, input logic [8:0] a, input logic [15:0] d,
                           input int hold_cycles);
      logic       in_rng;
      logic [1:0] er;
      logic       efd;
      in_rng = int'(a) < depth_of[u];
      er     = in_rng ? 2'b00 : 2'b10;
      addr[u] = a; wdata[u] = d; wr[u] = 1'b1; rd[u] = 1'b0;
      hold[u] = (hold_cycles > 0);
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         checks++;
         if (wreq[u] !== 1'b1) begin
            errors++; $display("FAIL hold_wreq u%0d a=%0h: got %b want 1", u, a, wreq[u]);
         end
         checks++;
         if (wcnt[u] !== 10'(exp_cnt[u])) begin
            errors++; $display("FAIL hold_count u%0d: got %0d want %0d", u, wcnt[u], exp_cnt[u]);
         end
         @(posedge clk); #1;
         if (i == hold_cycles - 1) hold[u] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (wreq[u] !== 1'b0) begin
         errors++; $display("FAIL write_wreq u%0d a=%0h: got %b want 0", u, a, wreq[u]);
      end
      checks++;
      if (resp[u] !== er) begin
         errors++; $display("FAIL write_resp u%0d a=%0h: got %b want %b", u, a, resp[u], er);
      end
      efd = 1'b0;
      if (in_rng) begin
         model[u][a] = d;
         if (int'(a) == depth_of[u] - 1) begin
            exp_cnt[u] = 0; efd = 1'b1;
         end else if (exp_cnt[u] < depth_of[u]) begin
            exp_cnt[u]++;
         end
      end
      @(posedge clk); #1;
      wr[u] = 1'b0;
      @(negedge clk);
      checks++;
      if (wcnt[u] !== 10'(exp_cnt[u])) begin
         errors++; $display("FAIL write_count u%0d a=%0h: got %0d want %0d", u, a, wcnt[u], exp_cnt[u]);
      end
      checks++;
      if (fd[u] !== efd) begin
         errors++; $display("FAIL frame_done u%0d a=%0h: got %b want %b", u, a, fd[u], efd);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_read(input int u, input logic [8:0] a, input logic with_wr,
                          input logic [15:0] wd);
      logic       in_rng;
      int         waits;
      logic [15:0] ed;
      logic [1:0]  er;
      in_rng = int'(a) < depth_of[u];
      exp_q.push_back(in_rng ? model[u][a] : 16'h0000);
      exp_resp_q.push_back((!in_rng || with_wr) ? 2'b10 : 2'b00);
      addr[u] = a; rd[u] = 1'b1; wr[u] = with_wr; wdata[u] = wd; hold[u] = 1'b0;
      waits = 0;
      forever begin
         @(negedge clk);
         if (wreq[u] !== 1'b1) break;
         waits++;
         if (waits > 40) break;
      end
      ed = exp_q.pop_front();
      er = exp_resp_q.pop_front();
      checks++;
      if (waits !== rw_of[u]) begin
         errors++; $display("FAIL read_waits u%0d a=%0h: got %0d want %0d", u, a, waits, rw_of[u]);
      end
      checks++;
      if (rdata[u] !== ed) begin
         errors++; $display("FAIL read_data u%0d a=%0h: got %h want %h", u, a, rdata[u], ed);
      end
      checks++;
      if (resp[u] !== er) begin
         errors++; $display("FAIL read_resp u%0d a=%0h: got %b want %b", u, a, resp[u], er);
      end
      @(posedge clk); #1;
      rd[u] = 1'b0; wr[u] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd = 2'b11; wr = 2'b00; hold = 2'b00;
      addr[0] = 9'h00A; addr[1] = 9'h00A; wdata[0] = '0; wdata[1] = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (wreq !== 2'b11) begin
            errors++; $display("FAIL reset_wreq cycle %0d: got %b want 11", i, wreq);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (rdata[u] !== 16'h0 || fd[u] !== 1'b0 || wcnt[u] !== 10'd0 || resp[u] !== 2'b00) begin
            errors++;
            $display("FAIL reset_values u%0d: got data=%h fd=%b cnt=%0d resp=%b want 0/0/0/00",
                     u, rdata[u], fd[u], wcnt[u], resp[u]);
         end
      end
      @(posedge clk); #1;
      rd = 2'b00;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (st[0] !== 2'd0 || st[1] !== 2'd0) begin
         errors++; $display("FAIL abandon_idle: got %0d/%0d want 0/0", st[0], st[1]);
      end
   endtask

   task automatic test_write_read();
      do_write(0, 9'h00A, 16'hF0F0, 0);
      do_read(0, 9'h00A, 1'b0, 16'h0);
      do_write(1, 9'h00A, 16'hBEEF, 0);
      do_write(1, 9'h003, 16'h1234, 0);
      do_read(1, 9'h00A, 1'b0, 16'h0);
   endtask

   task automatic test_hold();
      do_write(0, 9'h005, 16'h5A5A, 3);
      do_read(0, 9'h005, 1'b0, 16'h0);
   endtask

   task automatic test_back_to_back();
      do_read(0, 9'h00A, 1'b0, 16'h0);
      do_read(0, 9'h005, 1'b0, 16'h0);
      do_read(0, 9'h00A, 1'b0, 16'h0);
   endtask

   task automatic test_out_of_range();
      do_write(1, 9'd400, 16'h7777, 0);
      do_read(1, 9'd400, 1'b0, 16'h0);
   endtask

   task automatic test_collision();
      do_read(1, 9'h003, 1'b1, 16'hDEAD);
      do_read(1, 9'h003, 1'b0, 16'h0);
   endtask

   task automatic test_frame();
      int start_fd;
      start_fd = fd_cnt;
      for (int a = 0; a < 512; a++) begin
         do_write(0, 9'(a), 16'(a) ^ 16'hA5A5, (a % 97 == 13) ? $urandom_range(1, 3) : 0);
      end
      @(negedge clk);
      checks++;
      if (fd[0] !== 1'b0) begin
         errors++; $display("FAIL frame_pulse_width: got %b want 0", fd[0]);
      end
      checks++;
      if (fd_cnt - start_fd !== 1) begin
         errors++; $display("FAIL frame_pulse_count: got %0d want 1", fd_cnt - start_fd);
      end
      @(posedge clk); #1;
      do_read(0, 9'h1FF, 1'b0, 16'h0);
      do_read(0, 9'h00A, 1'b0, 16'h0);
      do_write(0, 9'h002, 16'h0F0F, 0);
   endtask

   task automatic test_reset_mid_read();
      int          waits;
      logic [15:0] ed;
      logic [1:0]  er;
      addr[1] = 9'h00A; rd[1] = 1'b1; wr[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (st[1] !== 2'd1 || wreq[1] !== 1'b1) begin
         errors++; $display("FAIL midread_rwait: got st=%0d wreq=%b want 1/1", st[1], wreq[1]);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (wreq[1] !== 1'b1) begin
         errors++; $display("FAIL midread_rst_wreq: got %b want 1", wreq[1]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      exp_q.push_back(model[1][9'h00A]);
      exp_resp_q.push_back(2'b00);
      @(negedge clk);
      checks++;
      if (st[1] !== 2'd0 || wcnt[0] !== 10'd0) begin
         errors++; $display("FAIL midread_idle: got st=%0d cnt0=%0d want 0/0", st[1], wcnt[0]);
      end
      waits = 0;
      while (wreq[1] === 1'b1 && waits <= 40) begin
         waits++;
         @(negedge clk);
      end
      ed = exp_q.pop_front();
      er = exp_resp_q.pop_front();
      checks++;
      if (waits !== 3) begin
         errors++; $display("FAIL midread_waits: got %0d want 3", waits);
      end
      checks++;
      if (rdata[1] !== ed || resp[1] !== er) begin
         errors++; $display("FAIL midread_data: got %h/%b want %h/%b", rdata[1], resp[1], ed, er);
      end
      @(posedge clk); #1;
      rd[1] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rd = '0; wr = '0; hold = '0; addr = '0; wdata = '0;
      test_reset();
      test_write_read();
      test_hold();
      test_back_to_back();
      test_out_of_range();
      test_collision();
      test_frame();
      test_reset_mid_read();
      do_read(1, 9'h003, 1'b0, 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/avalon_sample_slave.md
# avalon_sample_slave

Avalon-MM slave that terminates the FFT block's Avalon master: it accepts 16-bit sample writes into a 512-entry buffer, serves reads back with a programmable number of wait states, flags out-of-range accesses, and pulses `frame_done` when the last buffer location is written. It sits on the fabric opposite `avalonMaster` and is the bus responder for that master in system simulation and on chip.

## Interface
- `DEPTH`, 512, buffer entries; addresses `0..DEPTH-1` are valid.
- `ADDR_W`, 9, address width.
- `DATA_W`, 16, data width.
- `READ_WAIT`, 1, waitrequest cycles per read; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `slave_address` in ADDR_W: word address.
- `slave_read` in 1: read request, held by the master until waitrequest is low.
- `slave_write` in 1: write request, held by the master until waitrequest is low.
- `slave_write_data` in DATA_W: write data.
- `hold` in 1: local stall; forces waitrequest on writes.
- `slave_read_data` out DATA_W: registered read data.
- `slave_waitrequest` out 1: stall to master; combinational.
- `slave_response` out 2: `00` OKAY, `10` SLVERR; combinational, meaningful only when the access completes.
- `frame_done` out 1: one-cycle pulse after the write to `DEPTH-1` commits.
- `write_count` out ADDR_W+1: committed in-range writes in the current frame.

## Operation
- FSM states: IDLE, RWAIT, RDONE. Reset state is IDLE.
- Reset values while `rst` is high and on the first cycle after release:
  - `slave_read_data`=0, `frame_done`=0, `write_count`=0, `slave_response`=00.
  - `slave_waitrequest`=1 while `rst` is high.
- Buffer contents are not reset.
- IDLE, write only:
  - `hold`=1 → waitrequest 1, nothing committed.
  - `hold`=0 → waitrequest 0, and the write commits at this edge.
  - In range: store data, `write_count`+1, response 00.
  - Out of range: data dropped, count unchanged, response 10.
- IDLE, read (with or without write):
  - Waitrequest 1; latch the address and the range check.
  - Next state: RWAIT with wait counter = READ_WAIT-1 if READ_WAIT>1, else RDONE.
  - The buffer word is loaded into `slave_read_data` on entry to RDONE. Out-of-range reads load 0.
- Read and write asserted together: the read is served and the write is dropped, never committed. The read completes with response 10.
- RWAIT: waitrequest 1. Decrement the counter; move to RDONE when it reaches 0.
- RDONE: waitrequest 0; read data is valid; response is 00, or 10 for an out-of-range or collided access. Return to IDLE.
- `hold` has no effect on reads.
- If the master deasserts `slave_read` during RWAIT (a protocol violation), the FSM still completes to RDONE and then IDLE, with no lockup.
- Committed write to `DEPTH-1`:
  - `frame_done`=1 on the next cycle.
  - `write_count` returns to 0 on the same edge the pulse is registered.
- Otherwise `write_count` saturates at DEPTH.
- Writes to earlier addresses after the last one start a new frame count.

## Timing
- Write latency is 0 wait cycles when `hold`=0; data is visible to a read starting the next cycle.
- A read occupies READ_WAIT+1 cycles: READ_WAIT cycles with waitrequest=1, then one completion cycle with waitrequest=0 and data valid.
- Back-to-back reads: a new read may be presented in the cycle after RDONE.
- `frame_done` rises exactly 1 cycle after the committing edge and lasts exactly 1 cycle.
- `rst` asserted mid-read: the FSM goes to IDLE on that edge, waitrequest=1, and the pending read is discarded. A master still holding `slave_read` after release gets a fresh full-latency read.

## Test plan
- Reset with `slave_read`=1: waitrequest=1 throughout reset; read_data=0, frame_done=0, write_count=0 after release.
- Write with `hold`=0: write 0x00A → 0xF0F0 with 0 waits, response 00, write_count=1. Reading 0x00A with READ_WAIT=1 gives waitrequest high 1 cycle, then data 0xF0F0 and response 00.
- `hold`=1 for 3 cycles during a write to 0x005 → waitrequest high 3 cycles, no commit. Commit on the cycle `hold` drops; write_count advances by 1.
- Write all 512 addresses in order → frame_done pulses once, 1 cycle after the write to 0x1FF; write_count is 0 afterwards.
- Simultaneous read and write to 0x003, READ_WAIT=3 → 3 waitrequest cycles, then response 10; memory at 0x003 unchanged.
- Reset asserted during the second RWAIT cycle → FSM in IDLE, no completion seen. The re-issued read completes after READ_WAIT waits.
